// File: rtl/ras_unit_if.sv
// Request/response bundle between the ID/EX call/return detect logic and the return address stack.
// The master drives requests and the slave (ras_unit) returns the predicted target and status.
interface ras_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  logic                     push_signal_in;
  logic                     pop_signal_in;
  logic                     stall_signal_in;
  logic [XLEN-1:0]          push_addr_in;
  logic [XLEN-1:0]          fwd_data_in;
  logic                     ras_mux_src_signal_in;
  logic                     checkpoint_signal_in;
  logic                     restore_signal_in;
  logic [XLEN-1:0]          top_addr_out;
  logic                     valid_out;
  logic [$clog2(DEPTH):0]   count_out;
  logic                     overflow_out;
  logic                     underflow_out;

  modport master (
    output push_signal_in, pop_signal_in, stall_signal_in, push_addr_in, fwd_data_in,
           ras_mux_src_signal_in, checkpoint_signal_in, restore_signal_in,
    input  top_addr_out, valid_out, count_out, overflow_out, underflow_out
  );

  modport slave (
    input  push_signal_in, pop_signal_in, stall_signal_in, push_addr_in, fwd_data_in,
           ras_mux_src_signal_in, checkpoint_signal_in, restore_signal_in,
    output top_addr_out, valid_out, count_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/ras_unit.sv
// Circular return address stack with overwrite-on-full and reported underflow.
// Define RAS_CHECKPOINT_EN to add a {tos_ptr, count} snapshot for misprediction restore.
module ras_unit #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic       clk_in,
  input logic       rst_in,
  ras_unit_if.slave ras_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   tos_q, tos_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] push_val;

`ifdef RAS_CHECKPOINT_EN
  logic [PW-1:0]   snap_tos_q;
  logic [CW-1:0]   snap_count_q;
`else
  logic            unused_checkpoint;
  assign unused_checkpoint = ras_if.checkpoint_signal_in;
`endif

  assign push_val = ras_if.ras_mux_src_signal_in ? ras_if.fwd_data_in : ras_if.push_addr_in;

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    if (ras_if.restore_signal_in) begin
`ifdef RAS_CHECKPOINT_EN
      tos_d   = snap_tos_q;
      count_d = snap_count_q;
`else
      tos_d   = '0;
      count_d = '0;
`endif
    end else if (!ras_if.stall_signal_in) begin
      if (ras_if.push_signal_in && ras_if.pop_signal_in && count_q != '0) begin
        // Coroutine swap: replace the top in place.
        wr_en  = 1'b1;
        wr_idx = tos_q;
      end else if (ras_if.push_signal_in) begin
        tos_d  = tos_q + PW'(1);
        wr_en  = 1'b1;
        wr_idx = tos_q + PW'(1);
        if (count_q == CW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (ras_if.pop_signal_in) begin
        if (count_q != '0) begin
          tos_d   = tos_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= push_val;
      end
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef RAS_CHECKPOINT_EN
  // Snapshot reflects the state after this cycle's update, so it is taken from the _d values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      snap_tos_q   <= '0;
      snap_count_q <= '0;
    end else if (ras_if.checkpoint_signal_in) begin
      snap_tos_q   <= tos_d;
      snap_count_q <= count_d;
    end
  end
`endif

  assign ras_if.top_addr_out  = (count_q != '0) ? mem_q[tos_q] : '0;
  assign ras_if.valid_out     = (count_q != '0);
  assign ras_if.count_out     = count_q;
  assign ras_if.overflow_out  = ovf_q;
  assign ras_if.underflow_out = unf_q;
endmodule
